// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants for the VGA timing generator and drawing stages.
// No logic; constants plus one helper for counter widths.
// Derived sync start/end values are half-open windows [START, END).
package vga_pkg;

   localparam int BIT          = 10;

   localparam int H_VISIBLE    = 640;
   localparam int H_FRONT      = 16;
   localparam int H_SYNC       = 96;
   localparam int H_BACK       = 48;
   localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

   localparam int V_VISIBLE    = 480;
   localparam int V_FRONT      = 10;
   localparam int V_SYNC       = 2;
   localparam int V_BACK       = 33;
   localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int TICK_FRAMES  = 8;

   // Counter width for n states, never below one bit so a degenerate count still elaborates.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrap counter for one screen axis with a registered active-low sync window.
// Latency: position and sync are registered from the next-state value, so both describe the same pixel.
// Backpressure: none; i_inc gates advancement, everything holds when it is low.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int BIT        = vga_pkg::BIT,
   parameter int TOTAL      = vga_pkg::H_TOTAL,
   parameter int SYNC_START = vga_pkg::H_SYNC_START,
   parameter int SYNC_END   = vga_pkg::H_SYNC_END
)(
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_inc,
   output logic [BIT-1:0] o_pos,
   output logic [BIT-1:0] o_pos_nxt,
   output logic           o_wrap,
   output logic           o_sync_n
);

   logic [BIT-1:0] r_pos;
   logic           r_sync_n;
   logic [BIT-1:0] w_pos_nxt;
   logic           w_at_end;
   logic           w_sync_n_nxt;

   // o_wrap flags the terminal count; the caller qualifies it with its own increment.
   assign w_at_end = (r_pos == BIT'(TOTAL - 1));

   // Next position: hold, step, or wrap to zero at the terminal count.
   always_comb begin
      w_pos_nxt = r_pos;
      if (i_inc) begin
         w_pos_nxt = w_at_end ? '0 : r_pos + BIT'(1);
      end
   end

   assign w_sync_n_nxt = !((w_pos_nxt >= BIT'(SYNC_START)) && (w_pos_nxt < BIT'(SYNC_END)));

   // Position and sync registered together so they always describe the same pixel.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pos    <= '0;
         r_sync_n <= 1'b1;
      end else begin
         r_pos    <= w_pos_nxt;
         r_sync_n <= w_sync_n_nxt;
      end
   end

   assign o_pos     = r_pos;
   assign o_pos_nxt = w_pos_nxt;
   assign o_wrap    = w_at_end;
   assign o_sync_n  = r_sync_n;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel position, syncs, display enable, line/frame strobes (game_tick with FRAME_TICK_EN).
// Latency: every output is registered and aligned with the x/y position it describes.
// Backpressure: none; i_pix_en gates advancement, strobes read 0 on cycles after a disabled one.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int BIT       = vga_pkg::BIT,
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_pkg::H_FRONT,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BACK    = vga_pkg::H_BACK,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_pkg::V_FRONT,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BACK    = vga_pkg::V_BACK
`ifdef FRAME_TICK_EN
   ,
   parameter int TICK_FRAMES = vga_pkg::TICK_FRAMES
`endif
)(
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_pix_en,
   output logic [BIT-1:0] o_x_pos,
   output logic [BIT-1:0] o_y_pos,
   output logic           o_hsync,
   output logic           o_vsync,
   output logic           o_display_active,
   output logic           o_line_start,
   output logic           o_frame_start,
   output logic           o_game_tick
);

   localparam int HT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int HSS = H_VISIBLE + H_FRONT;
   localparam int HSE = HSS + H_SYNC;
   localparam int VT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int VSS = V_VISIBLE + V_FRONT;
   localparam int VSE = VSS + V_SYNC;

   logic [BIT-1:0] w_x_nxt;
   logic [BIT-1:0] w_y_nxt;
   logic           w_h_end;
   logic           w_v_end;
   logic           w_line_evt;
   logic           w_frame_evt;
   logic           w_active_nxt;

   logic           r_display_active;
   logic           r_line_start;
   logic           r_frame_start;

   // A line event is an enabled step off the last pixel; it also steps the vertical axis.
   assign w_line_evt  = i_pix_en & w_h_end;
   assign w_frame_evt = w_line_evt & w_v_end;

   vga_axis_counter #(
      .BIT        (BIT),
      .TOTAL      (HT),
      .SYNC_START (HSS),
      .SYNC_END   (HSE)
   ) u_h_cnt (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_inc     (i_pix_en),
      .o_pos     (o_x_pos),
      .o_pos_nxt (w_x_nxt),
      .o_wrap    (w_h_end),
      .o_sync_n  (o_hsync)
   );

   vga_axis_counter #(
      .BIT        (BIT),
      .TOTAL      (VT),
      .SYNC_START (VSS),
      .SYNC_END   (VSE)
   ) u_v_cnt (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_inc     (w_line_evt),
      .o_pos     (o_y_pos),
      .o_pos_nxt (w_y_nxt),
      .o_wrap    (w_v_end),
      .o_sync_n  (o_vsync)
   );

   assign w_active_nxt = (w_x_nxt < BIT'(H_VISIBLE)) && (w_y_nxt < BIT'(V_VISIBLE));

   // Display enable follows the next position; strobes are one clock wide and only fire on enabled wraps.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_display_active <= 1'b1;
         r_line_start     <= 1'b0;
         r_frame_start    <= 1'b0;
      end else begin
         r_display_active <= w_active_nxt;
         r_line_start     <= w_line_evt;
         r_frame_start    <= w_frame_evt;
      end
   end

   assign o_display_active = r_display_active;
   assign o_line_start     = r_line_start;
   assign o_frame_start    = r_frame_start;

`ifdef FRAME_TICK_EN
   localparam int TW = clog2_min1(TICK_FRAMES);

   logic [TW-1:0] r_frame_cnt;
   logic          r_game_tick;
   logic          w_cnt_end;

   assign w_cnt_end = (r_frame_cnt == TW'(TICK_FRAMES - 1));

   // Count frames; the tick lands on the same clock as the frame_start that completes the group.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_frame_cnt <= '0;
         r_game_tick <= 1'b0;
      end else begin
         r_game_tick <= w_frame_evt & w_cnt_end;
         if (w_frame_evt) begin
            r_frame_cnt <= w_cnt_end ? '0 : r_frame_cnt + TW'(1);
         end
      end
   end

   assign o_game_tick = r_game_tick;
`else
   assign o_game_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line-level timing, shrunken instance for frame-level timing.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Full-size 640x480 instance
   logic       rst_n, pix_en;
   logic [9:0] x_pos, y_pos;
   logic       hsync, vsync, de, ls, fs, gt;

   // Small instance: H 8/2/3/2 (total 15, hsync 10..12), V 6/1/2/1 (total 10, vsync 7..8)
   logic       s_rst_n, s_pix_en;
   logic [3:0] s_x, s_y;
   logic       s_hs, s_vs, s_de, s_ls, s_fs, s_gt;

`ifdef FRAME_TICK_EN
   localparam bit TICK_ON = 1'b1;
`else
   localparam bit TICK_ON = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   int seq_err, hs_low, hs_first, hs_last, ls_cnt, ls_at;
   int vs_low, de_cnt, fs_cnt, fs_at, fs_at2, fs_no_ls, gt_cnt, gt_bad, gt_f1, gt_f2;
   int en_cnt;

   vga_timing_gen u_dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_pix_en         (pix_en),
      .o_x_pos          (x_pos),
      .o_y_pos          (y_pos),
      .o_hsync          (hsync),
      .o_vsync          (vsync),
      .o_display_active (de),
      .o_line_start     (ls),
      .o_frame_start    (fs),
      .o_game_tick      (gt)
   );

   vga_timing_gen #(
      .BIT       (4),
      .H_VISIBLE (8),
      .H_FRONT   (2),
      .H_SYNC    (3),
      .H_BACK    (2),
      .V_VISIBLE (6),
      .V_FRONT   (1),
      .V_SYNC    (2),
      .V_BACK    (1)
   ) u_small (
      .i_clk            (clk),
      .i_rst_n          (s_rst_n),
      .i_pix_en         (s_pix_en),
      .o_x_pos          (s_x),
      .o_y_pos          (s_y),
      .o_hsync          (s_hs),
      .o_vsync          (s_vs),
      .o_display_active (s_de),
      .o_line_start     (s_ls),
      .o_frame_start    (s_fs),
      .o_game_tick      (s_gt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and land on the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1; s_rst_n = 1'b1; pix_en = 1'b0; s_pix_en = 1'b0;
      #2;
      rst_n = 1'b0; s_rst_n = 1'b0;
      repeat (3) tick();

      // Reset state is pixel (0,0)
      check("rst_x", x_pos, 0);
      check("rst_y", y_pos, 0);
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_de", de, 1);
      check("rst_line_start", ls, 0);
      check("rst_frame_start", fs, 0);
      check("rst_game_tick", gt, 0);

      // ---- Full-size: one line plus one pixel ----
      rst_n = 1'b1; pix_en = 1'b1;
      seq_err = 0; hs_low = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; ls_at = -1;
      for (int k = 1; k <= 801; k++) begin
         tick();
         if (x_pos != 10'(k % 800) || y_pos != 10'(k / 800)) seq_err++;
         if (!hsync) begin
            hs_low++;
            if (hs_first < 0) hs_first = int'(x_pos);
            hs_last = int'(x_pos);
         end
         if (ls) begin ls_cnt++; ls_at = k; end
         if (k == 639) check("de_x639", de, 1);
         if (k == 640) check("de_x640", de, 0);
         if (k == 800) begin
            check("y_after_wrap", y_pos, 1);
            check("ls_at_wrap", ls, 1);
            check("de_line1_x0", de, 1);
         end
      end
      check("line_seq_err", seq_err, 0);
      check("hsync_low_cnt", hs_low, 96);
      check("hsync_first_x", hs_first, 656);
      check("hsync_last_x", hs_last, 751);
      check("ls_cnt_line", ls_cnt, 1);
      check("ls_pos_line", ls_at, 800);

      // pix_en low: counters hold
      pix_en = 1'b0;
      repeat (5) tick();
      check("hold_x", x_pos, 1);
      check("hold_y", y_pos, 1);
      check("hold_ls", ls, 0);

      // ---- Small instance: 17 frames at full enable ----
      s_rst_n = 1'b1; s_pix_en = 1'b1;
      seq_err = 0; vs_low = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0; fs_at = -1;
      fs_no_ls = 0; gt_cnt = 0; gt_bad = 0; gt_f1 = 0; gt_f2 = 0;
      for (int k = 1; k <= 2550; k++) begin
         tick();
         if (s_x != 4'(k % 15) || s_y != 4'((k / 15) % 10)) seq_err++;
         if (k <= 150) begin
            if (!s_vs) vs_low++;
            if (s_de) de_cnt++;
            if (s_ls) ls_cnt++;
         end
         if (s_fs) begin
            fs_cnt++;
            if (fs_cnt == 1) fs_at = k;
            if (!s_ls) fs_no_ls++;
         end
         if (s_gt) begin
            gt_cnt++;
            if (!s_fs) gt_bad++;
            if (gt_cnt == 1) gt_f1 = fs_cnt;
            else if (gt_cnt == 2) gt_f2 = fs_cnt;
         end
         if (k == 7)   check("s_de_x7", s_de, 1);
         if (k == 8)   check("s_de_x8", s_de, 0);
         if (k == 9)   check("s_hs_x9", s_hs, 1);
         if (k == 10)  check("s_hs_x10", s_hs, 0);
         if (k == 13)  check("s_hs_x13", s_hs, 1);
         if (k == 75)  check("s_de_y5", s_de, 1);
         if (k == 90)  check("s_de_y6", s_de, 0);
         if (k == 104) check("s_vs_y6_end", s_vs, 1);
         if (k == 105) check("s_vs_y7", s_vs, 0);
         if (k == 134) check("s_vs_y8_end", s_vs, 0);
         if (k == 135) check("s_vs_y9", s_vs, 1);
      end
      check("s_seq_err", seq_err, 0);
      check("s_vsync_low_cnt", vs_low, 30);
      check("s_de_cnt", de_cnt, 48);
      check("s_ls_cnt_frame", ls_cnt, 10);
      check("s_fs_first", fs_at, 150);
      check("s_fs_cnt17", fs_cnt, 17);
      check("s_fs_without_ls", fs_no_ls, 0);
      check("s_gt_cnt", gt_cnt, TICK_ON ? 2 : 0);
      check("s_gt_not_on_fs", gt_bad, 0);
      check("s_gt_frame_a", gt_f1, TICK_ON ? 8 : 0);
      check("s_gt_frame_b", gt_f2, TICK_ON ? 16 : 0);

      // ---- Small instance: pix_en alternating 1,0 ----
      s_rst_n = 1'b0;
      tick();
      s_rst_n = 1'b1;
      seq_err = 0; ls_cnt = 0; fs_cnt = 0; fs_at = -1; fs_at2 = -1;
      for (int c = 1; c <= 600; c++) begin
         s_pix_en = (c % 2 == 1);
         tick();
         en_cnt = (c + 1) / 2;
         if (s_x != 4'(en_cnt % 15) || s_y != 4'((en_cnt / 15) % 10)) seq_err++;
         if (s_ls) ls_cnt++;
         if (s_fs) begin
            fs_cnt++;
            if (fs_cnt == 1) fs_at = c;
            else if (fs_cnt == 2) fs_at2 = c;
         end
      end
      check("t_seq_err", seq_err, 0);
      check("t_ls_high_clks", ls_cnt, 20);
      check("t_fs_cnt", fs_cnt, 2);
      check("t_fs_first", fs_at, 299);
      check("t_fs_second", fs_at2, 599);

      // ---- Small instance: async reset inside the sync corner (11,8) ----
      s_pix_en = 1'b1;
      s_rst_n = 1'b0;
      tick();
      s_rst_n = 1'b1;
      repeat (131) tick();
      check("m_x_before", s_x, 11);
      check("m_y_before", s_y, 8);
      check("m_hs_before", s_hs, 0);
      check("m_vs_before", s_vs, 0);
      #2;
      s_rst_n = 1'b0;
      #1;
      check("m_rst_x", s_x, 0);
      check("m_rst_y", s_y, 0);
      check("m_rst_hs", s_hs, 1);
      check("m_rst_vs", s_vs, 1);
      check("m_rst_de", s_de, 1);
      check("m_rst_ls", s_ls, 0);
      check("m_rst_fs", s_fs, 0);
      @(negedge clk);
      s_rst_n = 1'b1;
      fs_cnt = 0; fs_at = -1;
      for (int k = 1; k <= 150; k++) begin
         tick();
         if (s_fs) begin
            fs_cnt++;
            if (fs_cnt == 1) fs_at = k;
         end
      end
      check("m_fs_cnt", fs_cnt, 1);
      check("m_fs_pos", fs_at, 150);
      s_pix_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
